token_copy: RTL and testbench
=============================

TOKEN_COPY -- requirements
Module: token_copy

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port token_valid, input, 1 bit: a token is offered this cycle.
REQ-004 SHALL have port token_ready, output, 1 bit: the block accepts a token this cycle.
REQ-005 SHALL have port token_kind, input, 2 bits: 0 literal, 1 match, 2 end marker, 3 reserved.
REQ-006 SHALL have port token_literal, input, 8 bits: the literal byte.
REQ-007 SHALL have port token_offset, input, 11 bits: match distance, legal range 1..2047.
REQ-008 SHALL have port token_length, input, 12 bits: match length, legal range 1..4095.
REQ-009 SHALL have port hist_rd_en, output, 1 bit: history RAM read strobe.
REQ-010 SHALL have port hist_rd_addr, output, 11 bits: history RAM read address.
REQ-011 SHALL have port hist_rd_data, input, 8 bits: RAM data, valid one cycle after hist_rd_en.
REQ-012 SHALL have port decode_result, output, 8 bits: emitted byte, feeding the output stage.
REQ-013 SHALL have port result_valid, output, 1 bit: decode_result is valid.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the end marker drains.
REQ-015 SHALL have port token_err, output, 1 bit: one-cycle pulse on an illegal token.

Function
REQ-016 SHALL implement an FSM with states IDLE, COPY and DRAIN; token_ready SHALL be 1 only in IDLE.
REQ-017 Token handshake SHALL complete on a cycle where token_valid and token_ready are both 1.
REQ-018 A literal SHALL issue one byte in the cycle after acceptance; the FSM SHALL stay in IDLE.
REQ-019 A legal match SHALL go to COPY and issue one byte per cycle for token_length cycles, then return to IDLE.
REQ-020 SHALL keep an 11-bit issue pointer, incremented per issued byte and wrapping 2047 -> 0.
REQ-021 For match bytes, hist_rd_addr SHALL be (issue pointer - offset) mod 2048.
REQ-022 Two-stage pipeline: S0 issues the byte (RAM read for a match); S1 selects the source and registers decode_result and result_valid.
REQ-023 Latency from issue to result_valid SHALL be 2 cycles, regardless of byte type.
REQ-024 SHALL keep an 8-byte shadow of the last emitted bytes, updated whenever result_valid is registered.
REQ-025 In S1, match bytes with offset <= 8 SHALL take shadow[offset-1]; offset > 8 SHALL take hist_rd_data.
REQ-026 hist_rd_en SHALL assert only for match bytes with offset > 8.
REQ-027 An end marker SHALL go to DRAIN; done SHALL pulse the cycle after the last result_valid, or 2 cycles after acceptance if nothing is in flight; then IDLE.
REQ-028 Offset 0, length 0 or token_kind 3 SHALL pulse token_err the cycle after acceptance, issue nothing and stay in IDLE.
REQ-029 Offset larger than the bytes emitted so far is not detected; output SHALL be whatever the source holds.
REQ-030 result_valid SHALL never assert for two bytes in one cycle, and no byte SHALL be dropped or reordered.

Reset
REQ-031 On rst low: FSM to IDLE, pointer 0, shadow 0, pipeline flushed.
REQ-032 On rst low: token_ready 0, hist_rd_en 0, hist_rd_addr 0, decode_result 0, result_valid 0, done 0, token_err 0.
REQ-033 token_ready SHALL assert the first cycle after rst deasserts.
REQ-034 Reset mid-COPY SHALL abandon the match, with no further result_valid.

Structure
REQ-035 Token kind encodings, history depth 2048 and shadow depth 8 SHALL live in a shared package (lzs_pkg).
REQ-036 The shadow register file SHALL be a sub-module, hist_shadow (write-on-valid, 3-bit indexed read).

Verification
REQ-037 Literals 0x41, 0x42 back to back -> result_valid with 0x41 at T+2 and 0x42 at T+3 after acceptance.
REQ-038 Literal 0x5A, then match offset 1 length 4 -> five consecutive bytes 0x5A, all from the shadow, hist_rd_en never high.
REQ-039 Emit 20 literals 0..19, then match offset 16 length 3 -> hist_rd_addr 4,5,6 and outputs 4,5,6 from the RAM model.
REQ-040 Pointer at 2046, match offset 10 length 4 -> hist_rd_addr 2036..2039 and pointer wraps to 2.
REQ-041 Match with offset 0 -> token_err pulse, no result_valid; next literal 0x11 is emitted normally.
REQ-042 End marker during a length-5 copy tail -> done pulses the cycle after the 5th byte; rst low mid-copy -> all outputs 0 immediately.

Source files
------------

// File: rtl/lzs_pkg.sv
// lzs_pkg: shared constants for the token copy engine.
//   - token kind encodings carried on token_kind
//   - history window depth (2048) and its address width
//   - shadow depth (8), the short-distance window kept inside the block
//   - token_is_legal(): the single definition of an acceptable token
package lzs_pkg;

    localparam logic [1:0] KIND_LITERAL = 2'd0;
    localparam logic [1:0] KIND_MATCH   = 2'd1;
    localparam logic [1:0] KIND_END     = 2'd2;
    localparam logic [1:0] KIND_RSVD    = 2'd3;

    localparam int BYTE_W       = 8;
    localparam int LEN_W        = 12;
    localparam int HIST_DEPTH   = 2048;
    localparam int HIST_AW      = $clog2(HIST_DEPTH);
    localparam int SHADOW_DEPTH = 8;
    localparam int SHADOW_AW    = $clog2(SHADOW_DEPTH);

    // Literals and end markers are always legal; a match needs a non-zero
    // distance and a non-zero length; the reserved kind is never legal.
    function automatic logic token_is_legal(
        input logic [1:0]         kind,
        input logic [HIST_AW-1:0] offset,
        input logic [LEN_W-1:0]   length
    );
        logic legal;
        legal = 1'b1;
        if (kind == KIND_RSVD) begin
            legal = 1'b0;
        end else if (kind == KIND_MATCH) begin
            legal = (offset != '0) && (length != '0);
        end
        return legal;
    endfunction

endpackage

// File: rtl/token_copy_if.sv
// token_copy_if: token bus between a token producer (master) and the copy
// engine (slave).
//   token_valid   master -> slave  a token is offered this cycle
//   token_ready   slave  -> master the engine takes a token this cycle
//   token_kind    master -> slave  literal / match / end / reserved
//   token_literal master -> slave  literal byte
//   token_offset  master -> slave  match distance
//   token_length  master -> slave  match length
//
// Handshake: a token transfers on every rising clk edge where token_valid
// and token_ready are both 1. The master holds valid and all payload fields
// stable until that edge; ready may be 1 without valid and does not depend
// on valid.
interface token_copy_if;
    import lzs_pkg::*;

    logic               token_valid;
    logic               token_ready;
    logic [1:0]         token_kind;
    logic [BYTE_W-1:0]  token_literal;
    logic [HIST_AW-1:0] token_offset;
    logic [LEN_W-1:0]   token_length;

    modport master (
        output token_valid, token_kind, token_literal, token_offset, token_length,
        input  token_ready
    );

    modport slave (
        input  token_valid, token_kind, token_literal, token_offset, token_length,
        output token_ready
    );
endinterface

// File: rtl/token_copy_hist_shadow.sv
// hist_shadow: the last SHADOW_DEPTH emitted bytes, newest at index 0.
//   clk, rst_n  clock, asynchronous active-low reset (contents to 0)
//   i_wr_en     push i_wr_data as the newest byte, ageing the others
//   i_wr_data   byte being emitted
//   i_rd_idx    0 = newest byte, SHADOW_DEPTH-1 = oldest
//   o_rd_data   combinational read of the indexed entry
module hist_shadow
    import lzs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr_en,
    input  logic [BYTE_W-1:0]    i_wr_data,
    input  logic [SHADOW_AW-1:0] i_rd_idx,
    output logic [BYTE_W-1:0]    o_rd_data
);

    logic [BYTE_W-1:0] r_mem [SHADOW_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[0] <= i_wr_data;
            for (int i = 1; i < SHADOW_DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/token_copy.sv
// token_copy: turns literal / match / end tokens into a byte stream.
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   tok            token bus (slave side)
//   hist_rd_en     history RAM read strobe (far matches only)
//   hist_rd_addr   history RAM read address, (pointer - offset) mod 2048
//   hist_rd_data   history RAM data, valid the cycle after hist_rd_en
//   decode_result  emitted byte
//   result_valid   decode_result holds a new byte this cycle
//   done           one-cycle pulse once an end marker has drained
//   token_err      one-cycle pulse after an illegal token is taken
//   o_dbg_state    current FSM state (IDLE/COPY/DRAIN)
//
// Pipeline: S0 issues a byte (literal pending, or one COPY cycle, which also
// drives the RAM read). S1 picks literal / shadow / RAM data and registers
// decode_result. A byte taken at edge T appears on result_valid after T+2.
module token_copy
    import lzs_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    token_copy_if.slave        tok,
    output logic               hist_rd_en,
    output logic [HIST_AW-1:0] hist_rd_addr,
    input  logic [BYTE_W-1:0]  hist_rd_data,
    output logic [BYTE_W-1:0]  decode_result,
    output logic               result_valid,
    output logic               done,
    output logic               token_err,
    output logic [1:0]         o_dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COPY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // FSM and S0 state
    logic [1:0]         r_state;
    logic               r_lit_pend;
    logic [BYTE_W-1:0]  r_lit_byte;
    logic [HIST_AW-1:0] r_offset;
    logic [LEN_W-1:0]   r_remaining;
    logic [HIST_AW-1:0] r_ptr;
    logic               r_drain_first;
    logic               r_done;
    logic               r_err;

    // S1 state
    logic                 r_s1_vld;
    logic                 r_s1_match;
    logic                 r_s1_use_ram;
    logic [BYTE_W-1:0]    r_s1_lit;
    logic [SHADOW_AW-1:0] r_s1_idx;

    // output stage
    logic [BYTE_W-1:0] r_result;
    logic              r_result_vld;

    logic                 w_accept;
    logic                 w_legal;
    logic                 w_copy;
    logic                 w_issue;
    logic                 w_far;
    logic                 w_pipe_busy;
    logic [SHADOW_AW-1:0] w_shadow_idx;
    logic [BYTE_W-1:0]    w_shadow_byte;
    logic [BYTE_W-1:0]    w_byte;

    // Ready is gated by rst so it reads 0 while reset is held, even though
    // the state register already sits in IDLE.
    assign tok.token_ready = rst && (r_state == ST_IDLE);

    assign w_accept     = tok.token_valid && tok.token_ready;
    assign w_legal      = token_is_legal(tok.token_kind, tok.token_offset, tok.token_length);
    assign w_copy       = (r_state == ST_COPY);
    assign w_issue      = r_lit_pend || w_copy;
    assign w_far        = (r_offset > HIST_AW'(SHADOW_DEPTH));
    assign w_pipe_busy  = w_issue || r_s1_vld;
    // offset 1..8 -> shadow index 0..7 (offset 8 wraps to 7 in 3 bits)
    assign w_shadow_idx = r_offset[SHADOW_AW-1:0] - SHADOW_AW'(1);

    // Near matches never touch the RAM; their bytes come from the shadow.
    assign hist_rd_en   = w_copy && w_far;
    assign hist_rd_addr = hist_rd_en ? (r_ptr - r_offset) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_lit_pend    <= 1'b0;
            r_lit_byte    <= '0;
            r_offset      <= '0;
            r_remaining   <= '0;
            r_drain_first <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_lit_pend <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_err <= 1'b1;
                        end else begin
                            case (tok.token_kind)
                                KIND_LITERAL: begin
                                    r_lit_pend <= 1'b1;
                                    r_lit_byte <= tok.token_literal;
                                end
                                KIND_MATCH: begin
                                    r_state     <= ST_COPY;
                                    r_offset    <= tok.token_offset;
                                    r_remaining <= tok.token_length;
                                end
                                default: begin
                                    r_state       <= ST_DRAIN;
                                    r_drain_first <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_COPY: begin
                    r_remaining <= r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Once S0/S1 are empty: if the last byte is on the output
                    // now, done follows it next cycle; if nothing was in
                    // flight, spend one extra cycle so done lands two cycles
                    // after the end marker was taken.
                    if (!w_pipe_busy) begin
                        if (r_result_vld || !r_drain_first) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_drain_first <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // S0 -> S1 register, issue pointer and output stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_vld     <= 1'b0;
            r_s1_match   <= 1'b0;
            r_s1_use_ram <= 1'b0;
            r_s1_lit     <= '0;
            r_s1_idx     <= '0;
            r_ptr        <= '0;
            r_result     <= '0;
            r_result_vld <= 1'b0;
        end else begin
            r_s1_vld     <= w_issue;
            r_s1_match   <= w_copy;
            r_s1_use_ram <= w_far;
            r_s1_lit     <= r_lit_byte;
            r_s1_idx     <= w_shadow_idx;
            if (w_issue) begin
                r_ptr <= r_ptr + HIST_AW'(1);
            end
            r_result_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_result <= w_byte;
            end
        end
    end

    // S1 source select
    always_comb begin
        w_byte = r_s1_lit;
        if (r_s1_match) begin
            w_byte = r_s1_use_ram ? hist_rd_data : w_shadow_byte;
        end
    end

    // The shadow is written in the same edge that registers result_valid, so
    // the next byte in S1 already sees this one at index 0.
    hist_shadow u_shadow (
        .clk       (clk),
        .rst_n     (rst),
        .i_wr_en   (r_s1_vld),
        .i_wr_data (w_byte),
        .i_rd_idx  (r_s1_idx),
        .o_rd_data (w_shadow_byte)
    );

    assign decode_result = r_result;
    assign result_valid  = r_result_vld;
    assign done          = r_done;
    assign token_err     = r_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_token_copy.sv
// tb_token_copy: directed bench for token_copy with a byte/address
// scoreboard, a reference history model and an external history RAM model.
module tb_token_copy;
    import lzs_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    token_copy_if tok();

    logic        hist_rd_en;
    logic [10:0] hist_rd_addr;
    logic [7:0]  hist_rd_data = 8'h00;
    logic [7:0]  decode_result;
    logic        result_valid;
    logic        done;
    logic        token_err;
    logic [1:0]  dbg_state;

    token_copy dut (
        .clk           (clk),
        .rst           (rst),
        .tok           (tok),
        .hist_rd_en    (hist_rd_en),
        .hist_rd_addr  (hist_rd_addr),
        .hist_rd_data  (hist_rd_data),
        .decode_result (decode_result),
        .result_valid  (result_valid),
        .done          (done),
        .token_err     (token_err),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- history RAM model (output stage writes it) ----------------
    logic [7:0]  ram [2048];
    logic [10:0] ram_wptr = 11'd0;

    always @(posedge clk) begin
        if (!rst) begin
            ram_wptr <= 11'd0;
        end else if (result_valid) begin
            ram[ram_wptr] <= decode_result;
            ram_wptr      <= ram_wptr + 11'd1;
        end
        if (hist_rd_en) begin
            hist_rd_data <= ram[hist_rd_addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic [10:0] exp_addr_q[$];
    logic [7:0]  model_hist [2048];
    logic [10:0] model_ptr;
    int checks   = 0;
    int failures = 0;
    int rd_en_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_addr_q.delete();
        model_ptr = 11'd0;
        for (int i = 0; i < 2048; i++) begin
            model_hist[i] = 8'h00;
        end
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) chk("spurious_result_valid", 32'(result_valid), 32'd0);
            else                   chk("result_byte", 32'(decode_result), 32'(exp_q.pop_front()));
        end
        if (hist_rd_en) begin
            rd_en_count++;
            if (exp_addr_q.size() == 0) chk("spurious_hist_rd_en", 32'(hist_rd_en), 32'd0);
            else                        chk("hist_rd_addr", 32'(hist_rd_addr), 32'(exp_addr_q.pop_front()));
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [1:0] kind, input logic [7:0] lit_b,
                        input logic [10:0] off, input logic [11:0] len);
        int waited = 0;
        tok.token_kind    = kind;
        tok.token_literal = lit_b;
        tok.token_offset  = off;
        tok.token_length  = len;
        tok.token_valid   = 1'b1;
        while (tok.token_ready !== 1'b1 && waited < 5000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 5000) chk("send_ready_timeout", 32'(tok.token_ready), 32'd1);
        @(posedge clk); #1;
        tok.token_valid = 1'b0;
    endtask

    // Expected bytes come from the reference history, not from the DUT.
    task automatic put_token(input logic [1:0] kind, input logic [7:0] lit_b,
                             input logic [10:0] off, input logic [11:0] len);
        logic [10:0] a;
        logic [7:0]  b;
        if (kind == KIND_LITERAL) begin
            exp_q.push_back(lit_b);
            model_hist[model_ptr] = lit_b;
            model_ptr++;
        end else if (kind == KIND_MATCH && off != 11'd0 && len != 12'd0) begin
            for (int i = 0; i < int'(len); i++) begin
                a = model_ptr - off;
                b = model_hist[a];
                if (off > 11'd8) exp_addr_q.push_back(a);
                exp_q.push_back(b);
                model_hist[model_ptr] = b;
                model_ptr++;
            end
        end
        send(kind, lit_b, off, len);
    endtask

    task automatic lit(input logic [7:0] b);
        put_token(KIND_LITERAL, b, 11'd0, 12'd0);
    endtask

    task automatic match(input logic [10:0] off, input logic [11:0] len);
        put_token(KIND_MATCH, 8'h00, off, len);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tok.token_valid = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // ---------------- directed sequence ----------------
    int base;

    initial begin
        tok.token_valid   = 1'b0;
        tok.token_kind    = 2'd0;
        tok.token_literal = 8'h00;
        tok.token_offset  = 11'd0;
        tok.token_length  = 12'd0;
        clear_model();
        rst = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_token_ready",   32'(tok.token_ready), 32'd0);
        chk("rst_hist_rd_en",    32'(hist_rd_en),      32'd0);
        chk("rst_hist_rd_addr",  32'(hist_rd_addr),    32'd0);
        chk("rst_decode_result", 32'(decode_result),   32'd0);
        chk("rst_result_valid",  32'(result_valid),    32'd0);
        chk("rst_done",          32'(done),            32'd0);
        chk("rst_token_err",     32'(token_err),       32'd0);
        chk("rst_state_idle",    32'(dbg_state),       32'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 32'(tok.token_ready), 32'd1);

        // two literals back to back: 0x41 after T+2, 0x42 after T+3
        lit(8'h41);
        lit(8'h42);
        @(negedge clk);
        chk("lit_lat_t1_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("lit_lat_t2_valid", 32'(result_valid), 32'd1);
        chk("lit_lat_t2_byte",  32'(decode_result), 32'h41);
        @(negedge clk);
        chk("lit_lat_t3_valid", 32'(result_valid), 32'd1);
        chk("lit_lat_t3_byte",  32'(decode_result), 32'h42);
        repeat (4) @(negedge clk);

        // literal then offset-1 run: five consecutive 0x5A, no RAM reads
        base = rd_en_count;
        lit(8'h5A);
        match(11'd1, 12'd4);
        @(negedge clk);
        chk("run_pre_gap", 32'(result_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("run_valid", 32'(result_valid), 32'd1);
            chk("run_byte",  32'(decode_result), 32'h5A);
        end
        @(negedge clk);
        chk("run_post_gap",      32'(result_valid), 32'd0);
        chk("run_no_hist_rd_en", 32'(rd_en_count),  32'(base));

        // illegal tokens: reserved kind, length 0, offset 0
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      put_token(KIND_RSVD,  8'h33, 11'd4, 12'd2);
            else if (k == 1) put_token(KIND_MATCH, 8'h00, 11'd2, 12'd0);
            else             put_token(KIND_MATCH, 8'h00, 11'd0, 12'd3);
            @(negedge clk);
            chk("err_pulse",     32'(token_err), 32'd1);
            chk("err_no_result", 32'(result_valid), 32'd0);
            @(negedge clk);
            chk("err_pulse_end", 32'(token_err), 32'd0);
            chk("err_stay_idle", 32'(dbg_state), 32'd0);
        end
        lit(8'h11);
        repeat (4) @(negedge clk);
        chk("after_err_literal_out", 32'(exp_q.size()), 32'd0);

        // end marker queued behind a length-5 copy
        match(11'd3, 12'd5);
        send(KIND_END, 8'h00, 11'd0, 12'd0);
        @(negedge clk);
        chk("drain_last_byte_valid", 32'(result_valid), 32'd1);
        chk("drain_done_early",      32'(done), 32'd0);
        @(negedge clk);
        chk("drain_done_pulse", 32'(done), 32'd1);
        chk("drain_done_no_rv", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("drain_done_end", 32'(done), 32'd0);
        chk("drain_to_idle",  32'(tok.token_ready), 32'd1);

        // end marker with nothing in flight
        repeat (4) @(posedge clk);
        #1;
        send(KIND_END, 8'h00, 11'd0, 12'd0);
        @(negedge clk);
        chk("empty_drain_ready_low", 32'(tok.token_ready), 32'd0);
        chk("empty_drain_t1", 32'(done), 32'd0);
        @(negedge clk);
        chk("empty_drain_t2", 32'(done), 32'd0);
        @(negedge clk);
        chk("empty_drain_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("empty_drain_done_end", 32'(done), 32'd0);

        // pointer back to 0, then 20 literals and a far match at offset 16
        do_reset();
        for (int i = 0; i < 20; i++) lit(8'(i));
        match(11'd16, 12'd3);
        repeat (6) @(negedge clk);
        chk("far_match_addrs_seen", 32'(exp_addr_q.size()), 32'd0);
        chk("far_match_bytes_seen", 32'(exp_q.size()), 32'd0);

        // fill to pointer 2046, then a far match that wraps the pointer
        for (int i = 23; i < 2046; i++) lit(8'((i * 37 + 5) & 255));
        match(11'd10, 12'd4);
        match(11'd12, 12'd1);   // pointer is 2 here -> reads address 2038
        repeat (6) @(negedge clk);
        chk("wrap_addrs_seen", 32'(exp_addr_q.size()), 32'd0);
        chk("wrap_bytes_seen", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a long far copy
        match(11'd9, 12'd100);
        repeat (3) @(posedge clk);
        #2;
        chk("midcopy_rd_en_before", 32'(hist_rd_en), 32'd1);
        rst = 1'b0;
        clear_model();
        #1;
        chk("midcopy_token_ready",   32'(tok.token_ready), 32'd0);
        chk("midcopy_hist_rd_en",    32'(hist_rd_en),      32'd0);
        chk("midcopy_hist_rd_addr",  32'(hist_rd_addr),    32'd0);
        chk("midcopy_decode_result", 32'(decode_result),   32'd0);
        chk("midcopy_result_valid",  32'(result_valid),    32'd0);
        chk("midcopy_done",          32'(done),            32'd0);
        chk("midcopy_token_err",     32'(token_err),       32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midcopy_ready_after", 32'(tok.token_ready), 32'd1);
        chk("midcopy_state_idle",  32'(dbg_state), 32'd0);
        repeat (10) @(negedge clk);
        lit(8'h77);
        repeat (4) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
